// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronise, debounce, edge pulses, toggle flag and hold-to-repeat.
module button_conditioner #(
  parameter int N = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int REPEAT_EN = 0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Pins,
  output logic [N-1:0] Level,
  output logic [N-1:0] Press,
  output logic [N-1:0] Release,
  output logic [N-1:0] Toggle
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(RMAX) + 1;
  localparam logic IDLE_PIN = ACTIVE_LOW != 0;
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0] cnt;
    logic s, accept, hit, lv, pr, rl, tg;
    assign s = sr[SYNC_STAGES-1] ^ IDLE_PIN;
    assign accept = (s != lv) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge Clk)
      if (Reset) begin
        sr  <= {SYNC_STAGES{IDLE_PIN}};
        cnt <= '0;
        lv  <= 1'b0;
        pr  <= 1'b0;
        rl  <= 1'b0;
        tg  <= 1'b0;
      end else begin
        sr  <= {sr[SYNC_STAGES-2:0], Pins[i]};
        cnt <= (s == lv || accept) ? '0 : cnt + 1'b1;
        lv  <= accept ? s : lv;
        pr  <= (accept && s) || hit;
        rl  <= accept && !s;
        tg  <= tg ^ (accept && s);
      end
    if (REPEAT_EN != 0) begin : g_rep
      logic [HW-1:0] hc;
      logic rep;
      // rep selects the first (delay) interval versus the steady repeat period; hc restarts at every pulse
      assign hit = lv && !accept && (hc == (rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));
      always_ff @(posedge Clk)
        if (Reset || !lv || accept) begin
          hc  <= '0;
          rep <= 1'b0;
        end else if (hit) begin
          hc  <= '0;
          rep <= 1'b1;
        end else
          hc <= hc + 1'b1;
    end else begin : g_norep
      assign hit = 1'b0;
    end
    assign Level[i]   = lv;
    assign Press[i]   = pr;
    assign Release[i] = rl;
    assign Toggle[i]  = tg;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven, directed and random checks against a time-based behavioural model.
module tb_button_conditioner;
  localparam int SYNC = 2, DEB = 4, RD = 10, RP = 3, LEN = SYNC + DEB;
  logic Clk = 0, Reset = 1;
  logic [1:0] Pins = 2'b11, Level, Press, Release, Toggle;
  int total = 0, bad = 0, cyc = 0;
  bit hist[2][LEN];
  logic [1:0] ml, mp, mr, mt;
  int held[2];
  int press0_t[$], rel0_t[$], press1_t[$];

  button_conditioner #(.N(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .Clk(Clk), .Reset(Reset), .Pins(Pins), .Level(Level), .Press(Press),
    .Release(Release), .Toggle(Toggle));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Accept when the last DEB synchronised samples all disagree with the level; repeats by elapsed time.
  task automatic model(input logic r, input logic [1:0] p);
    for (int c = 0; c < 2; c++) begin
      mp[c] = 0;
      mr[c] = 0;
      if (r) begin
        for (int k = 0; k < LEN; k++) hist[c][k] = 0;
        ml[c] = 0;
        mt[c] = 0;
        held[c] = -1;
      end else begin
        bit acc;
        for (int k = LEN - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = (p[c] == 1'b0);
        acc = 1;
        for (int k = SYNC; k < LEN; k++) if (hist[c][k] == ml[c]) acc = 0;
        if (acc) begin
          ml[c] = ~ml[c];
          if (ml[c]) begin
            mp[c] = 1;
            mt[c] = ~mt[c];
            held[c] = 0;
          end else begin
            mr[c] = 1;
            held[c] = -1;
          end
        end else if (ml[c]) begin
          held[c]++;
          if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) mp[c] = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] p);
    Reset = r;
    Pins = p;
    @(posedge Clk);
    #1;
    cyc++;
    model(r, p);
    chk("level", Level, ml);
    chk("press", Press, mp);
    chk("release", Release, mr);
    chk("toggle", Toggle, mt);
    if (Press[0]) press0_t.push_back(cyc);
    if (Release[0]) rel0_t.push_back(cyc);
    if (Press[1]) press1_t.push_back(cyc);
  endtask

  task automatic run(input logic r, input logic [1:0] p, input int n);
    for (int k = 0; k < n; k++) step(r, p);
  endtask

  typedef struct {
    logic r;
    logic [1:0] p, l, pr, rl, tg;
  } vec_t;
  vec_t tv[11];
  int exp_off[6] = '{0, 10, 13, 16, 19, 22};

  initial begin
    for (int k = 0; k < 3; k++) tv[k] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int k = 3; k < 8; k++) tv[k] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[8]  = '{1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01};
    tv[9]  = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    tv[10] = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 11; i++) begin
      step(tv[i].r, tv[i].p);
      chk($sformatf("tv%0d_level", i), Level, tv[i].l);
      chk($sformatf("tv%0d_press", i), Press, tv[i].pr);
      chk($sformatf("tv%0d_release", i), Release, tv[i].rl);
      chk($sformatf("tv%0d_toggle", i), Toggle, tv[i].tg);
    end
    run(0, 2'b11, 10);
    chk("first_release_count", rel0_t.size(), 1);

    press0_t.delete();
    for (int k = 0; k < 5; k++) begin
      run(0, 2'b10, 2);
      run(0, 2'b11, 2);
    end
    run(0, 2'b11, 10);
    chk("bounce_presses", press0_t.size(), 0);
    chk("bounce_level", Level[0], 1'b0);
    chk("bounce_toggle", Toggle[0], 1'b1);

    press0_t.delete();
    rel0_t.delete();
    run(0, 2'b10, 25);
    run(0, 2'b11, 10);
    chk("hold_press_count", press0_t.size(), 6);
    for (int k = 0; k < 6 && k < press0_t.size(); k++)
      chk($sformatf("hold_offset%0d", k), press0_t[k] - press0_t[0], exp_off[k]);
    chk("hold_release_count", rel0_t.size(), 1);
    if (rel0_t.size() > 0 && press0_t.size() > 0)
      chk("hold_release_offset", rel0_t[0] - press0_t[0], 25);
    chk("hold_toggle", Toggle[0], 1'b0);

    run(0, 2'b00, 5);
    chk("both_press_early", Press, 2'b00);
    step(0, 2'b00);
    chk("both_press", Press, 2'b11);
    chk("both_toggle", Toggle, 2'b11);
    run(0, 2'b11, 10);
    run(0, 2'b01, 6);
    chk("ch1_second_press", Press, 2'b10);
    chk("ch1_toggle_back", Toggle[1], 1'b0);
    run(0, 2'b11, 10);

    run(0, 2'b01, 2);
    run(1, 2'b01, 2);
    chk("rst_level", Level, 2'b00);
    chk("rst_toggle", Toggle, 2'b00);
    run(0, 2'b01, 5);
    chk("rst_press_early", Press, 2'b00);
    press1_t.delete();
    step(0, 2'b01);
    chk("rst_repress", Press, 2'b10);
    run(0, 2'b01, 9);
    chk("rst_no_early_repeat", press1_t.size(), 1);
    run(0, 2'b11, 12);

    for (int k = 0; k < 150; k++)
      run($urandom_range(0, 19) == 0, 2'($urandom), $urandom_range(1, 14));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel pushbutton/switch conditioner for the board-level inputs of the SLC-3 top level (Run, Continue, and any added keys). Each channel is synchronised to Clk, debounced by a stable-count filter, and turned into a clean level, single-cycle press/release pulses, a press-toggled flag, and optional hold-to-repeat press pulses. It replaces ad-hoc per-button logic so the processor FSM sees exactly one Run or Continue event per physical press.

## Interface
- N, 4, number of independent channels
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a change (>=1; 1 ms at 50 MHz)
- ACTIVE_LOW, 1, 1: pin low means pressed (DE2 KEYs); 0: pin high means pressed
- REPEAT_EN, 0, 1 enables hold-to-repeat Press pulses
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (>=1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- Pins  in  N  raw asynchronous button/switch inputs
- Level  out  N  debounced pressed state, 1 = pressed
- Press  out  N  one-cycle pulse on accepted press (and on repeats when REPEAT_EN=1)
- Release  out  N  one-cycle pulse on accepted release
- Toggle  out  N  flips on every accepted press (not on repeats)

## Operation
- Per channel, fully independent; no shared state between channels.
- Synchroniser: SYNC_STAGES flops; polarity normalised after last stage (s = ACTIVE_LOW ? ~sync : sync).
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES)+1 minimum, per clock edge:
  - s == Level: cnt <= 0.
  - s != Level and cnt == DEBOUNCE_CYCLES-1: Level <= s, cnt <= 0.
  - s != Level otherwise: cnt <= cnt+1.
- Press/Release are registered with Level: Press=1 on the edge Level goes 0->1, Release=1 on the edge Level goes 1->0; both 0 otherwise.
- Toggle <= ~Toggle on the same edge Press is set by an accepted press.
- Repeat (REPEAT_EN=1) hold counter hc:
  - cleared on accepted press and whenever Level=0.
  - while Level=1, hc counts; Press additionally pulses REPEAT_DELAY edges after the accepted press, then every REPEAT_PERIOD edges while still held.
  - hc saturates/reloads; must never wrap into a spurious pulse on long holds.
  - REPEAT_EN=0: hc logic absent, Press only on accepted press.
- Glitches: any excursion of s shorter than DEBOUNCE_CYCLES cycles resets cnt and produces no output change.

## Timing
- Reset (synchronous, takes effect at the edge it is sampled high): sync flops <= unpressed value, cnt <= 0, hc <= 0, Level=0, Press=0, Release=0, Toggle=0.
- Press latency: pin changes stable before edge 1; Level and Press assert after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release has identical latency.
- Press and Release never assert in the same cycle on one channel; at most one Press per accepted press.
- Reset mid-debounce discards cnt; a key held through reset is re-accepted as a new press exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge with Reset low.
- Reset while held with REPEAT_EN=1: no repeat pulses until a new accepted press.
- DEBOUNCE_CYCLES=1: latency SYNC_STAGES+1, still one pulse per press.
- Simultaneous presses on several channels: all channels pulse on the same edge, independently.

## Test plan
Bench parameters: N=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset held 3 cycles with Pins=2'b11 -> all outputs 0; Pins[0] low from edge 1 -> Level[0]=1, Press[0]=1 for exactly one cycle after edge 6, Toggle[0]=1, channel 1 unchanged.
- Pins[0] bounce low/high every 2 cycles for 20 cycles, then high -> no Level, Press, or Toggle change.
- Hold Pins[0] low 25 cycles after acceptance -> Press[0] pulses at acceptance, +10, +13, +16, +19, +22; Toggle[0] flips once; release -> Release[0] one pulse 6 edges later.
- Both pins driven low on the same cycle -> Press=2'b11 on the same edge; second press of channel 1 returns Toggle[1] to 0.
- Reset asserted 2 cycles into a debounce of Pins[1] (pin held low throughout) -> outputs cleared, Press[1] fires 6 edges after Reset deasserts, no repeat pulses before REPEAT_DELAY.
